dff_share_arbiter: RTL
======================

// Module: dff_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for a single shared WIDTH-bit D flip-flop register.
//  NREQ requesters compete to load the register over valid/ready handshakes.
//  After each load, the arbiter enforces a programmable hold window before the next grant.
//  Sits between the requester agents and the DFF datapath; q/q_owner/q_valid drive downstream consumers.
// PARAMETERS
//  NREQ        4  number of requesters (>=2)
//  WIDTH       8  data width of the shared register
//  HOLD_CYCLES 2  cycles the register is locked after a load (0 = back-to-back loads allowed)
// PORTS
//  clk        in   1                  system clock, all logic on posedge
//  rst        in   1                  synchronous, active-high reset
//  req_valid  in   NREQ               per-requester load request
//  req_data   in   NREQ*WIDTH         requester i data at [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ               one-hot grant; transfer when req_valid[i] & req_ready[i]
//  q          out  WIDTH              shared register contents
//  q_owner    out  $clog2(NREQ)       index of requester that last loaded q
//  q_valid    out  1                  q holds data loaded since reset
//  busy       out  1                  1 while in the HOLD window
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE, q=0, q_owner=0, q_valid=0, hold_cnt=0.
//   - last_grant=NREQ-1, so requester 0 has top priority first.
//   - req_ready=0 while rst is high.
//  States: IDLE, HOLD. busy = (state==HOLD).
//  IDLE:
//   - req_ready is combinational from req_valid: one-hot on the first valid index scanning
//     last_grant+1, +2, ... mod NREQ. All zeros if no valid.
//   - On transfer edge: q<=req_data[g], q_owner<=g, q_valid<=1, last_grant<=g.
//   - If HOLD_CYCLES>0: state<=HOLD, hold_cnt<=HOLD_CYCLES-1. Else stay IDLE.
//  HOLD:
//   - req_ready=0, q stable.
//   - hold_cnt==0 -> IDLE next cycle. Otherwise hold_cnt decrements.
//   - Total lock = HOLD_CYCLES cycles after the load edge.
//  Latency:
//   - req_ready can assert in the same cycle as req_valid (IDLE only).
//   - q updates at the transfer edge.
//   - Minimum spacing between loads is HOLD_CYCLES+1 cycles.
//  Round-robin wrap: pointer wraps from NREQ-1 to 0. Every continuously-valid requester
//   is granted within NREQ grants (no starvation).
//  Requester rule: hold req_valid and req_data stable until accepted. If valid drops
//   early, the arbiter re-arbitrates that cycle with no error state.
//  Single requester: re-granted every HOLD_CYCLES+1 cycles.
//  rst mid-HOLD: immediate return to the reset values above. Any in-flight transfer is
//   discarded (req_ready=0).
//  hold_cnt width: $clog2(HOLD_CYCLES+1), minimum 1 bit.
// TESTING
//  1. rst high 10 clk, all req_valid=1 -> req_ready=0, q=0, q_valid=0, busy=0 throughout;
//     on release, first grant to req 0.
//  2. NREQ=4, HOLD=2, all valid, data i=8'hA0+i -> grants 0,1,2,3,0 every 3 cycles;
//     q=A0,A1,A2,A3,A0; busy high 2 cycles after each load.
//  3. Only req 2 valid, data 8'h5C -> req_ready=4'b0100 same cycle; q=5C, q_owner=2
//     next edge; next grant 3 cycles later.
//  4. Last grant=3, req 0 and req 1 valid together -> req 0 wins (pointer wrap),
//     req 1 wins next window.
//  5. HOLD_CYCLES=0, reqs 1 and 3 valid -> alternating grants every cycle, busy stays 0.
//  6. rst asserted on 1st HOLD cycle after req 1 loads 8'h3F -> next cycle q=0,
//     q_valid=0, IDLE; first post-reset grant goes to req 0 if valid.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one shared WIDTH-bit
// register, with a programmable lock window after every load.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   req_valid  per-requester load request
//   req_data   requester i data at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant (IDLE only); transfer = valid & ready
//   q          shared register contents
//   q_owner    index of the requester that last loaded q
//   q_valid    q holds data loaded since reset
//   busy       high while the register is locked (HOLD)
module dff_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        q,
  output logic [$clog2(NREQ)-1:0] q_owner,
  output logic                    q_valid,
  output logic                    busy
);

  localparam int IW    = $clog2(NREQ);
  localparam int HW    = (HOLD_CYCLES > 0) ?
                         $clog2(HOLD_CYCLES + 1) : 1;
  localparam int HLOAD = (HOLD_CYCLES > 0) ?
                         HOLD_CYCLES - 1 : 0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   cnt_n;
  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   idx;
  logic            found;
  logic            xfer;

  // Scan starting just past the previous winner so every
  // continuously-valid requester is served within NREQ grants.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= cnt_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    cnt_n   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (xfer && (HOLD_CYCLES > 0)) begin
          state_n = HOLD;
          cnt_n   = HW'(HLOAD);
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = hold_cnt - 1'b1;
        end
      end
    endcase
  end

  // Outputs; grants are suppressed during reset so a
  // transfer can never coincide with a reset edge.
  always_comb begin
    busy      = (state == HOLD);
    req_ready = '0;
    if ((state == IDLE) && !rst) begin
      req_ready = grant;
    end
  end

  // Shared register datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      q_owner    <= '0;
      q_valid    <= 1'b0;
      last_grant <= IW'(NREQ - 1);
    end else if (xfer) begin
      q          <= req_data[gidx*WIDTH +: WIDTH];
      q_owner    <= gidx;
      q_valid    <= 1'b1;
      last_grant <= gidx;
    end
  end

endmodule
